// File: rtl/lsu_mc.sv
// Multi-cycle RISC-V load/store unit: req/ack bus master with lane steering,
// sign/zero extension, illegal/misaligned detection and a bus timeout.
module lsu_mc #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     base,
    input  logic [XLEN-1:0]     offset,
    input  logic [XLEN-1:0]     store_data,
    output logic                busy,
    output logic                done,
    output logic [1:0]          fault,
    output logic [XLEN-1:0]     load_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wmask,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned LSB   = $clog2(NB);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] F_OK      = 2'b00;
    localparam logic [1:0] F_MISALGN = 2'b01;
    localparam logic [1:0] F_ILLEGAL = 2'b10;
    localparam logic [1:0] F_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         fault_q, fault_d;
    logic [XLEN-1:0]    load_data_q, load_data_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]    mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]      mem_wmask_q, mem_wmask_d;
    logic [LSB-1:0]     lane_q, lane_d;
    logic [2:0]         f3_q, f3_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ADDR_W-1:0]  ea_c;
    logic [LSB-1:0]     lane_c;
    logic [7:0]         mask8_c;
    logic [2:0]         align_c;
    logic               legal_c;
    logic               misal_c;
    logic               timeout_c;
    logic [XLEN-1:0]    raw_c;
    logic [XLEN-1:0]    ext_c;

    // Address decode, legality and load extension
    always_comb begin
        ea_c   = ADDR_W'(base + offset);
        lane_c = ea_c[LSB-1:0];
        case (funct3[1:0])
            2'b00:   begin mask8_c = 8'h01; align_c = 3'b000; end
            2'b01:   begin mask8_c = 8'h03; align_c = 3'b001; end
            2'b10:   begin mask8_c = 8'h0F; align_c = 3'b011; end
            default: begin mask8_c = 8'hFF; align_c = 3'b111; end
        endcase
        if (is_store)
            legal_c = (funct3 inside {3'b000, 3'b001, 3'b010}) ||
                      ((XLEN == 64) && (funct3 == 3'b011));
        else
            legal_c = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                      ((XLEN == 64) && (funct3 inside {3'b011, 3'b110}));
        misal_c   = |(ea_c[2:0] & align_c);
        timeout_c = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

        raw_c = mem_rdata >> {lane_q, 3'b000};
        case (f3_q)
            3'b000:  ext_c = XLEN'($signed(raw_c[7:0]));
            3'b001:  ext_c = XLEN'($signed(raw_c[15:0]));
            3'b010:  ext_c = XLEN'($signed(raw_c[31:0]));
            3'b100:  ext_c = XLEN'(raw_c[7:0]);
            3'b101:  ext_c = XLEN'(raw_c[15:0]);
            3'b110:  ext_c = XLEN'(raw_c[31:0]);
            default: ext_c = raw_c;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (legal_c && !misal_c) ? S_REQ : S_DONE;
            S_REQ:  if (mem_ack || timeout_c) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and latched op fields
    always_comb begin
        busy_d      = (state_d == S_REQ);
        mem_req_d   = (state_d == S_REQ);
        done_d      = (state_d == S_DONE);
        fault_d     = fault_q;
        load_data_d = load_data_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        lane_d      = lane_q;
        f3_d        = f3_q;
        cnt_d       = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fault_d = !legal_c ? F_ILLEGAL : (misal_c ? F_MISALGN : F_OK);
                    if (legal_c && !misal_c) begin
                        mem_we_d    = is_store;
                        mem_addr_d  = {ea_c[ADDR_W-1:LSB], LSB'(0)};
                        mem_wdata_d = is_store ? XLEN'(store_data << {lane_c, 3'b000}) : '0;
                        mem_wmask_d = NB'({8'h00, mask8_c} << lane_c);
                        lane_d      = lane_c;
                        f3_d        = funct3;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    if (!mem_we_q) load_data_d = ext_c;
                end else if (timeout_c) begin
                    fault_d = F_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= F_OK;
            load_data_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            lane_q      <= '0;
            f3_q        <= '0;
            cnt_q       <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            lane_q      <= lane_d;
            f3_q        <= f3_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign load_data = load_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

endmodule
